// File: rtl/dest_drain_arbiter_pkg.sv
// Shared types and constants for the D0/D1 destination drain arbiter.
package dest_drain_arbiter_pkg;

  localparam int unsigned BW_DEF     = 6;
  localparam int unsigned WGT_W_DEF  = 4;
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned OCC_W      = 2;
  localparam int unsigned CNT_W      = 8;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SRV0 = 2'd1,
    SRV1 = 2'd2
  } state_e;

endpackage

// File: rtl/dest_drain_arbiter_out_skid_fifo.sv
// Two-entry {src,data} output FIFO; absorbs the word still in flight from a
// FIFO read when downstream stalls.
module dest_drain_arbiter_out_skid_fifo
  import dest_drain_arbiter_pkg::*;
#(
  parameter int unsigned W = BW_DEF + 1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [W-1:0]     head_o,
  output logic [OCC_W-1:0] occ_o
);

  logic [W-1:0]     mem0_q;
  logic [W-1:0]     mem1_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i & (occ_q != '0);
  assign do_push = push_i & ((occ_q != OCC_W'(SKID_DEPTH)) | do_pop);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (do_push) begin
        if (wr_ptr_q) mem1_q <= push_data_i;
        else          mem0_q <= push_data_i;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_o  = rd_ptr_q ? mem1_q : mem0_q;
  assign valid_o = (occ_q != '0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/dest_drain_arbiter.sv
// Weighted round-robin drain of the D0/D1 destination FIFOs onto one valid/ready
// channel. Optional per-source delivery counters when DRAIN_CNT_EN is defined.
module dest_drain_arbiter
  import dest_drain_arbiter_pkg::*;
#(
  parameter int unsigned BW    = BW_DEF,
  parameter int unsigned WGT_W = WGT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             active_out,
  input  logic             D0_empty,
  input  logic             D0_error_output,
  input  logic [BW-1:0]    D0_data_out,
  output logic             D0_rd,
  input  logic             D1_empty,
  input  logic             D1_error_output,
  input  logic [BW-1:0]    D1_data_out,
  output logic             D1_rd,
  input  logic [WGT_W-1:0] Weight_D0,
  input  logic [WGT_W-1:0] Weight_D1,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [BW-1:0]    Out_data,
  output logic             Out_src,
  output logic [1:0]       Err_seen
`ifdef DRAIN_CNT_EN
  ,
  output logic [CNT_W-1:0] Cnt_D0,
  output logic [CNT_W-1:0] Cnt_D1
`endif
);

  localparam int unsigned ENT_W = BW + 1;

  function automatic logic [WGT_W-1:0] eff_wgt(input logic [WGT_W-1:0] w);
    return (w == '0) ? WGT_W'(1) : w;
  endfunction

  state_e           state_q, state_d;
  logic [WGT_W-1:0] cnt_q, cnt_d;
  logic [WGT_W-1:0] wgt_q, wgt_d;
  logic [WGT_W-1:0] cnt_inc;
  logic             inflight_q;
  logic             inflight_src_q;
  logic [1:0]       err_q;
  logic             rd0_c, rd1_c;
  logic             elig0_c, elig1_c;
  logic             deq_c;
  logic             pop_ok_c;
  logic [2:0]       load_c;
  logic [OCC_W-1:0] occ;
  logic             skid_valid;
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] push_word;

  // A FIFO that has ever flagged an error stays out of arbitration until reset.
  assign elig0_c = ~D0_empty & ~D0_error_output & ~err_q[0];
  assign elig1_c = ~D1_empty & ~D1_error_output & ~err_q[1];

  assign deq_c    = skid_valid & Out_ready;
  assign load_c   = 3'(occ) + 3'(inflight_q);
  assign pop_ok_c = active_out & (load_c <= (3'd1 + 3'(deq_c)));
  assign cnt_inc  = cnt_q + WGT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wgt_d   = wgt_q;
    rd0_c   = 1'b0;
    rd1_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (elig0_c) begin
          state_d = SRV0;
          cnt_d   = '0;
          wgt_d   = eff_wgt(Weight_D0);
        end else if (elig1_c) begin
          state_d = SRV1;
          cnt_d   = '0;
          wgt_d   = eff_wgt(Weight_D1);
        end
      end
      SRV0: begin
        if (!elig0_c) begin
          cnt_d = '0;
          if (elig1_c) begin
            state_d = SRV1;
            wgt_d   = eff_wgt(Weight_D1);
          end else begin
            state_d = IDLE;
          end
        end else if (pop_ok_c) begin
          rd0_c = 1'b1;
          if (cnt_inc >= wgt_q) begin
            cnt_d = '0;
            if (elig1_c) begin
              state_d = SRV1;
              wgt_d   = eff_wgt(Weight_D1);
            end else begin
              wgt_d   = eff_wgt(Weight_D0);
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      SRV1: begin
        if (!elig1_c) begin
          cnt_d = '0;
          if (elig0_c) begin
            state_d = SRV0;
            wgt_d   = eff_wgt(Weight_D0);
          end else begin
            state_d = IDLE;
          end
        end else if (pop_ok_c) begin
          rd1_c = 1'b1;
          if (cnt_inc >= wgt_q) begin
            cnt_d = '0;
            if (elig0_c) begin
              state_d = SRV0;
              wgt_d   = eff_wgt(Weight_D0);
            end else begin
              wgt_d   = eff_wgt(Weight_D1);
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      wgt_q          <= '0;
      inflight_q     <= 1'b0;
      inflight_src_q <= SRC_D0;
      err_q          <= 2'b00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wgt_q          <= wgt_d;
      inflight_q     <= rd0_c | rd1_c;
      inflight_src_q <= rd1_c ? SRC_D1 : SRC_D0;
      err_q          <= err_q | {D1_error_output, D0_error_output};
    end
  end

  // FIFO read data is valid the cycle after rd, so capture uses the registered source tag.
  assign push_word = {inflight_src_q, (inflight_src_q == SRC_D1) ? D1_data_out : D0_data_out};

  dest_drain_arbiter_out_skid_fifo #(
    .W (ENT_W)
  ) u_skid (
    .clk         (clk),
    .reset_L     (reset_L),
    .push_i      (inflight_q),
    .push_data_i (push_word),
    .pop_i       (deq_c),
    .valid_o     (skid_valid),
    .head_o      (head),
    .occ_o       (occ)
  );

  assign D0_rd     = rd0_c;
  assign D1_rd     = rd1_c;
  assign Out_valid = skid_valid;
  assign Out_src   = head[BW];
  assign Out_data  = head[BW-1:0];
  assign Err_seen  = err_q;

`ifdef DRAIN_CNT_EN
  logic [CNT_W-1:0] cnt_d0_q;
  logic [CNT_W-1:0] cnt_d1_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_d0_q <= '0;
      cnt_d1_q <= '0;
    end else if (deq_c) begin
      if (Out_src == SRC_D1) cnt_d1_q <= cnt_d1_q + CNT_W'(1);
      else                   cnt_d0_q <= cnt_d0_q + CNT_W'(1);
    end
  end

  assign Cnt_D0 = cnt_d0_q;
  assign Cnt_D1 = cnt_d1_q;
`endif

endmodule

// File: tb/tb_dest_drain_arbiter.sv
// Scoreboard bench for dest_drain_arbiter: bench-side FIFO models, WRR reference
// order, randomized backpressure and active_out gating.
module tb_dest_drain_arbiter;

  localparam int BW    = 6;
  localparam int WGT_W = 4;
  localparam int DEPTH = 1024;

  logic             clk = 1'b0;
  logic             reset_L = 1'b0;
  logic             active_out = 1'b0;
  logic             D0_empty, D1_empty;
  logic             D0_error_output = 1'b0;
  logic             D1_error_output = 1'b0;
  logic [BW-1:0]    D0_data_out = '0;
  logic [BW-1:0]    D1_data_out = '0;
  logic             D0_rd, D1_rd;
  logic [WGT_W-1:0] Weight_D0 = 4'd1;
  logic [WGT_W-1:0] Weight_D1 = 4'd1;
  logic             Out_valid;
  logic             Out_ready = 1'b0;
  logic [BW-1:0]    Out_data;
  logic             Out_src;
  logic [1:0]       Err_seen;
`ifdef DRAIN_CNT_EN
  logic [7:0]       Cnt_D0, Cnt_D1;
`endif

  dest_drain_arbiter dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .active_out      (active_out),
    .D0_empty        (D0_empty),
    .D0_error_output (D0_error_output),
    .D0_data_out     (D0_data_out),
    .D0_rd           (D0_rd),
    .D1_empty        (D1_empty),
    .D1_error_output (D1_error_output),
    .D1_data_out     (D1_data_out),
    .D1_rd           (D1_rd),
    .Weight_D0       (Weight_D0),
    .Weight_D1       (Weight_D1),
    .Out_valid       (Out_valid),
    .Out_ready       (Out_ready),
    .Out_data        (Out_data),
    .Out_src         (Out_src),
    .Err_seen        (Err_seen)
`ifdef DRAIN_CNT_EN
    ,
    .Cnt_D0          (Cnt_D0),
    .Cnt_D1          (Cnt_D1)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [BW:0]   exp_q[$];
  logic [BW-1:0] ld0[$];
  logic [BW-1:0] ld1[$];
  logic          src_hist[$];
  logic [BW-1:0] mem0[DEPTH];
  logic [BW-1:0] mem1[DEPTH];
  int l0 = 0, l1 = 0;
  int p0 = 0, p1 = 0;
  logic rd0_s = 1'b0, rd1_s = 1'b0;
  int dv_total = 0, dv0 = 0, dv1 = 0;
  int pop_win = 0;
  int rdy_mode = 1, act_mode = 1;
  int bp_target = 0;
  logic err1_flag = 1'b0;

  assign D0_empty = (l0 == p0);
  assign D1_empty = (l1 == p1);

  // Source FIFO models: one-cycle read latency.
  always @(posedge clk) begin
    if (rd0_s) begin
      D0_data_out <= mem0[p0 % DEPTH];
      p0 <= p0 + 1;
    end
    if (rd1_s) begin
      D1_data_out <= mem1[p1 % DEPTH];
      p1 <= p1 + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       Out_ready = 1'b0;
      1:       Out_ready = 1'b1;
      2:       Out_ready = 1'($urandom);
      default: Out_ready = (dv_total < bp_target);
    endcase
    case (act_mode)
      0:       active_out = 1'b0;
      1:       active_out = 1'b1;
      default: active_out = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic monitor();
    logic [BW:0] e;
    forever begin
      @(negedge clk);
      rd0_s = D0_rd;
      rd1_s = D1_rd;
      if (!reset_L) begin
        dv0 = 0;
        dv1 = 0;
      end else begin
        if (D0_rd || D1_rd) pop_win++;
        if (D0_rd) check("rd0_legal", 32'(D0_empty | D0_error_output | D1_rd), 32'd0);
        if (D1_rd) check("rd1_legal", 32'(D1_empty | D1_error_output | err1_flag), 32'd0);
        if (Out_valid && Out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_src", 32'(Out_src), 32'(e[BW]));
            check("out_data", 32'(Out_data), 32'(e[BW-1:0]));
          end
          src_hist.push_back(Out_src);
          dv_total++;
          if (Out_src) dv1++;
          else         dv0++;
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input int n0, input int n1);
    logic [BW-1:0] w;
    ld0.delete();
    ld1.delete();
    for (int i = 0; i < n0; i++) begin
      w = BW'($urandom);
      mem0[l0 % DEPTH] = w;
      ld0.push_back(w);
      l0++;
    end
    for (int i = 0; i < n1; i++) begin
      w = BW'($urandom);
      mem1[l1 % DEPTH] = w;
      ld1.push_back(w);
      l1++;
    end
  endtask

  // Reference order: weighted round-robin over preloaded queues, D0 first.
  task automatic model_wrr(input int w0, input int w1, input bit use1);
    int i0 = 0, i1 = 0, cur = 0, cnt = 0;
    int e0, e1, n0, n1;
    e0 = (w0 == 0) ? 1 : w0;
    e1 = (w1 == 0) ? 1 : w1;
    n0 = ld0.size();
    n1 = use1 ? ld1.size() : 0;
    while (i0 < n0 || i1 < n1) begin
      if (cur == 0) begin
        if (i0 < n0) begin
          exp_q.push_back({1'b0, ld0[i0]});
          i0++;
          cnt++;
          if (cnt >= e0) begin
            cnt = 0;
            if (i1 < n1) cur = 1;
          end
        end else begin
          cur = 1;
          cnt = 0;
        end
      end else begin
        if (i1 < n1) begin
          exp_q.push_back({1'b1, ld1[i1]});
          i1++;
          cnt++;
          if (cnt >= e1) begin
            cnt = 0;
            if (i0 < n0) cur = 0;
          end
        end else begin
          cur = 0;
          cnt = 0;
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    tick(4);
    check(name, 32'(exp_q.size()), 32'd0);
    if (rdy_mode != 0) check("idle_after_drain", 32'(Out_valid), 32'd0);
  endtask

  initial begin
    int c;
    int p1_base;
    logic pat[8];
    pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    fork
      monitor();
    join_none

    // Reset held with data available.
    rdy_mode = 1;
    act_mode = 1;
    tick(2);
    load(3, 3);
    tick(3);
    check("rst_d0_rd", 32'(D0_rd), 32'd0);
    check("rst_d1_rd", 32'(D1_rd), 32'd0);
    check("rst_out_valid", 32'(Out_valid), 32'd0);
    check("rst_err_seen", 32'(Err_seen), 32'd0);
    check("rst_out_data", 32'(Out_data), 32'd0);
    check("rst_out_src", 32'(Out_src), 32'd0);
    model_wrr(1, 1, 1'b1);
    reset_L = 1'b1;
    wait_drain("drain_post_reset");

    // Directed WRR 3:1.
    Weight_D0 = 4'd3;
    Weight_D1 = 4'd1;
    src_hist.delete();
    load(8, 8);
    model_wrr(3, 1, 1'b1);
    wait_drain("drain_wrr31");
    for (int i = 0; i < 8; i++)
      check("wrr31_order", 32'(src_hist[i]), 32'(pat[i]));

    // Randomized weights, fill levels, backpressure and gating.
    for (int s = 0; s < 12; s++) begin
      rdy_mode = 2;
      act_mode = 2;
      Weight_D0 = WGT_W'($urandom_range(0, 15));
      Weight_D1 = WGT_W'($urandom_range(0, 15));
      load($urandom_range(0, 10), $urandom_range(0, 10));
      model_wrr(int'(Weight_D0), int'(Weight_D1), 1'b1);
      wait_drain("drain_random");
    end
    rdy_mode = 1;
    act_mode = 1;
    tick(2);

    // Backpressure after the first delivered word.
    Weight_D0 = 4'd2;
    Weight_D1 = 4'd2;
    bp_target = dv_total + 1;
    rdy_mode = 3;
    load(8, 0);
    model_wrr(2, 2, 1'b0);
    tick(8);
    pop_win = 0;
    tick(6);
    check("bp_buffered", 32'((p0 + p1) - dv_total), 32'd2);
    check("bp_no_rd", 32'(pop_win), 32'd0);
    check("bp_out_valid", 32'(Out_valid), 32'd1);
    rdy_mode = 1;
    wait_drain("drain_bp");

    // active_out gating.
    act_mode = 0;
    tick(1);
    load(4, 4);
    model_wrr(2, 2, 1'b1);
    pop_win = 0;
    tick(5);
    check("gate_no_pop", 32'(pop_win), 32'd0);
    act_mode = 1;
    c = 0;
    while (pop_win == 0 && c < 3) begin
      tick(1);
      c++;
    end
    check("gate_resume", 32'(pop_win != 0), 32'd1);
    wait_drain("drain_gate");

    // D1 error during the first D0 burst.
    Weight_D0 = 4'd3;
    Weight_D1 = 4'd1;
    p1_base = p1;
    c = p0;
    load(8, 8);
    model_wrr(3, 1, 1'b0);
    while (p0 == c && exp_q.size() != 0) tick(1);
    D1_error_output = 1'b1;
    err1_flag = 1'b1;
    tick(1);
    check("err_seen_set", 32'(Err_seen), 32'd2);
    wait_drain("drain_err");
    D1_error_output = 1'b0;
    tick(10);
    check("err_sticky", 32'(Err_seen), 32'd2);
    check("err_d1_never_popped", 32'(p1 - p1_base), 32'd0);

    // Reset in the middle of traffic.
    rdy_mode = 0;
    load(6, 0);
    tick(6);
    reset_L = 1'b0;
    tick(1);
    check("midrst_out_valid", 32'(Out_valid), 32'd0);
    check("midrst_err_seen", 32'(Err_seen), 32'd0);
    check("midrst_rd", 32'({D0_rd, D1_rd}), 32'd0);
    exp_q.delete();
    l0 = p0;
    l1 = p1;
    err1_flag = 1'b0;
    tick(2);
    reset_L = 1'b1;
    rdy_mode = 1;
    tick(2);
    Weight_D0 = 4'd2;
    Weight_D1 = 4'd1;
    load(5, 5);
    model_wrr(2, 1, 1'b1);
    wait_drain("drain_after_midrst");

`ifdef DRAIN_CNT_EN
    reset_L = 1'b0;
    tick(2);
    reset_L = 1'b1;
    tick(2);
    Weight_D0 = 4'd15;
    Weight_D1 = 4'd1;
    load(300, 5);
    model_wrr(15, 1, 1'b1);
    wait_drain("drain_cnt");
    check("cnt_d0_wrap", 32'(Cnt_D0), 32'd44);
    check("cnt_d1", 32'(Cnt_D1), 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
